// File: rtl/cla_seq_adder_ctrl_pkg.sv
// cla_seq_pkg: state encoding, nibble width and index sizing shared by the sequenced adder
package cla_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int idx_w(input int nib);
    return nib > 1 ? $clog2(nib) : 1;
  endfunction
endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// cla_seq_adder_ctrl_if: start/busy/done handshake and operand/result bus
// CLA_SEQ_ADDER_SUB_EN adds the sub request bit captured with start.
interface cla_seq_adder_ctrl_if #(parameter int WIDTH = 16);
  logic start, cin, busy, done, cout;
  logic [WIDTH-1:0] a, b, sum;
`ifdef CLA_SEQ_ADDER_SUB_EN
  logic sub;
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// cla_4bit: combinational 4-bit carry-lookahead adder used as the nibble datapath
module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit add sequenced one nibble per cycle through a single cla_4bit
// Define CLA_SEQ_ADDER_SUB_EN for a-b mode (b inverted, carry-in forced to 1).
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  cla_seq_adder_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW = idx_w(NIB);
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, c_n, sub;
  logic [NIBBLE_W-1:0] s_n;
`ifdef CLA_SEQ_ADDER_SUB_EN
  assign sub = bus.sub;
`else
  assign sub = 1'b0;
`endif
  cla_4bit u_cla (
    .a(a_r[idx*NIBBLE_W +: NIBBLE_W]),
    .b(b_r[idx*NIBBLE_W +: NIBBLE_W]),
    .cin(carry),
    .s(s_n),
    .cout(c_n)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      idx <= '0;
      carry <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
    end else case (state)
      RUN: begin
        bus.sum[idx*NIBBLE_W +: NIBBLE_W] <= s_n;
        carry <= c_n;
        if (idx == IW'(NIB - 1)) begin
          state <= DONE;
          idx <= '0;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.cout <= c_n;
        end else idx <= idx + 1'b1;
      end
      // IDLE and DONE accept start identically, giving back-to-back operation
      default: if (bus.start) begin
        state <= RUN;
        a_r <= bus.a;
        b_r <= sub ? ~bus.b : bus.b;
        carry <= sub | bus.cin;
        idx <= '0;
        bus.busy <= 1'b1;
        bus.done <= 1'b0;
      end else begin
        state <= IDLE;
        bus.done <= 1'b0;
      end
    endcase
endmodule
